// File: rtl/iob_regfile_w_r_np_pkg.sv
// Shared types and elaboration helpers for the wide-write / narrow-read register file.
package iob_regfile_w_r_np_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/iob_regfile_w_r_np_if.sv
// Write, read and clear-sweep signals of the register file, seen from the array (slave) side.
interface iob_regfile_w_r_np_if #(
  parameter int WADDR_W = 3,
  parameter int WDATA_W = 32,
  parameter int RDATA_W = 8,
  parameter int N_RD    = 2
);
  localparam int R       = WDATA_W / RDATA_W;
  localparam int RADDR_W = WADDR_W + $clog2(R);

  logic                      clr_i;
  logic                      busy_o;
  logic                      done_o;
  logic                      wready_o;
  logic [R-1:0]              wstrb_i;
  logic [WADDR_W-1:0]        waddr_i;
  logic [WDATA_W-1:0]        wdata_i;
  logic [N_RD-1:0]           ren_i;
  logic [N_RD*RADDR_W-1:0]   raddr_i;
  logic [N_RD*RDATA_W-1:0]   rdata_o;
  logic [N_RD-1:0]           rvalid_o;

  modport slave (
    input  clr_i, wstrb_i, waddr_i, wdata_i, ren_i, raddr_i,
    output busy_o, done_o, wready_o, rdata_o, rvalid_o
  );

  modport master (
    output clr_i, wstrb_i, waddr_i, wdata_i, ren_i, raddr_i,
    input  busy_o, done_o, wready_o, rdata_o, rvalid_o
  );
endinterface

// File: rtl/iob_regfile_w_r_np_rd_port.sv
// One narrow read port: row/slice select, optional same-cycle write forwarding, registered output.
module iob_regfile_w_r_np_rd_port #(
  parameter int WADDR_W = 3,
  parameter int RDATA_W = 8,
  parameter int R       = 4,
  parameter int RADDR_W = 5,
  parameter int BYPASS  = 1
) (
  input  logic                                          clk_i,
  input  logic                                          arst_n_i,
  input  logic                                          cke_i,
  input  logic                                          ren_i,
  input  logic [RADDR_W-1:0]                            raddr_i,
  input  logic [(1<<WADDR_W)-1:0][R-1:0][RDATA_W-1:0]   mem_i,
  input  logic                                          wen_i,
  input  logic [WADDR_W-1:0]                            waddr_i,
  input  logic [R-1:0]                                  wstrb_i,
  input  logic [R-1:0][RDATA_W-1:0]                     wdata_i,
  output logic [RDATA_W-1:0]                            rdata_o,
  output logic                                          rvalid_o
);
  localparam int SL_W = $clog2(R);
  localparam int SIW  = (SL_W > 0) ? SL_W : 1;

  logic [WADDR_W-1:0] w_row;
  logic [SIW-1:0]     w_sl;
  logic               w_hit;
  logic [RDATA_W-1:0] w_data;

  assign w_row = raddr_i[RADDR_W-1 -: WADDR_W];

  generate
    if (SL_W > 0) begin : g_sl
      assign w_sl = raddr_i[SIW-1:0];
    end else begin : g_nosl
      assign w_sl = '0;
    end
  endgenerate

  // Forwarding only matters when this exact slice is being written this cycle.
  assign w_hit  = (BYPASS != 0) && wen_i && (waddr_i == w_row) && wstrb_i[w_sl];
  assign w_data = w_hit ? wdata_i[w_sl] : mem_i[w_row][w_sl];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else if (cke_i) begin
      rvalid_o <= ren_i;
      if (ren_i) rdata_o <= w_data;
    end
  end
endmodule

// File: rtl/iob_regfile_w_r_np.sv
// Asymmetric register file: one strobed wide write port, N_RD registered narrow read ports, clear sweep.
module iob_regfile_w_r_np #(
  parameter int WADDR_W = 3,
  parameter int WDATA_W = 32,
  parameter int RDATA_W = 8,
  parameter int N_RD    = 2,
  parameter int BYPASS  = 1
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 cke_i,
  iob_regfile_w_r_np_if.slave  bus
);
  import iob_regfile_w_r_np_pkg::*;

  localparam int R       = WDATA_W / RDATA_W;
  localparam int RADDR_W = WADDR_W + $clog2(R);
  localparam int NROWS   = 1 << WADDR_W;

  generate
    if (!is_pow2(R) || (R * RDATA_W != WDATA_W)) begin : g_bad_cfg
      $error("WDATA_W/RDATA_W must be an integer power of two");
    end
  endgenerate

  state_t                              r_state, w_state_nxt;
  logic [WADDR_W-1:0]                  r_cnt, w_cnt_nxt;
  logic                                r_done, w_done_nxt;
  logic                                w_busy;
  logic [NROWS-1:0][R-1:0][RDATA_W-1:0] w_mem;
  logic [R-1:0][RDATA_W-1:0]           w_wdata;
  logic [N_RD-1:0][RDATA_W-1:0]        w_rdata;
  logic [N_RD-1:0]                     w_rvalid;

  assign w_busy       = (r_state == ST_CLEAR);
  assign w_wdata      = bus.wdata_i;
  assign bus.busy_o   = w_busy;
  assign bus.wready_o = !w_busy;
  assign bus.done_o   = r_done;
  assign bus.rdata_o  = w_rdata;
  assign bus.rvalid_o = w_rvalid;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.clr_i) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // Counter wraps back to zero on the last row, leaving it ready for the next sweep.
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= cke_i & w_done_nxt;
      if (cke_i) begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end
  end

  for (genvar gr = 0; gr < NROWS; gr++) begin : g_row
    for (genvar gs = 0; gs < R; gs++) begin : g_sl
      logic [RDATA_W-1:0] r_q;
      logic               w_wr_hit, w_clr_hit;

      assign w_wr_hit  = !w_busy && bus.wstrb_i[gs] && (bus.waddr_i == WADDR_W'(gr));
      assign w_clr_hit = w_busy && (r_cnt == WADDR_W'(gr));
      assign w_mem[gr][gs] = r_q;

      always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)                          r_q <= '0;
        else if (cke_i && (w_wr_hit || w_clr_hit)) r_q <= w_clr_hit ? '0 : w_wdata[gs];
      end
    end
  end

  for (genvar gk = 0; gk < N_RD; gk++) begin : g_rd
    iob_regfile_w_r_np_rd_port #(
      .WADDR_W (WADDR_W),
      .RDATA_W (RDATA_W),
      .R       (R),
      .RADDR_W (RADDR_W),
      .BYPASS  (BYPASS)
    ) u_rd (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .cke_i    (cke_i),
      .ren_i    (bus.ren_i[gk] & ~w_busy),
      .raddr_i  (bus.raddr_i[gk*RADDR_W +: RADDR_W]),
      .mem_i    (w_mem),
      .wen_i    (!w_busy),
      .waddr_i  (bus.waddr_i),
      .wstrb_i  (bus.wstrb_i),
      .wdata_i  (w_wdata),
      .rdata_o  (w_rdata[gk]),
      .rvalid_o (w_rvalid[gk])
    );
  end
endmodule

// File: tb/tb_iob_regfile_w_r_np.sv
// Bench: two instances (forwarding on/off) share stimulus; a slice-array model predicts every output.
module tb_iob_regfile_w_r_np;
  localparam int WADDR_W = 3, WDATA_W = 32, RDATA_W = 8, N_RD = 2;

  logic clk_i = 1'b0;
  logic arst_n_i = 1'b0;
  logic cke_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  iob_regfile_w_r_np_if #(.WADDR_W(WADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W), .N_RD(N_RD)) bus ();
  iob_regfile_w_r_np_if #(.WADDR_W(WADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W), .N_RD(N_RD)) bus_nb ();

  assign bus_nb.clr_i   = bus.clr_i;
  assign bus_nb.wstrb_i = bus.wstrb_i;
  assign bus_nb.waddr_i = bus.waddr_i;
  assign bus_nb.wdata_i = bus.wdata_i;
  assign bus_nb.ren_i   = bus.ren_i;
  assign bus_nb.raddr_i = bus.raddr_i;

  iob_regfile_w_r_np #(.WADDR_W(WADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W), .N_RD(N_RD), .BYPASS(1))
    u_dut (.clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .bus(bus));
  iob_regfile_w_r_np #(.WADDR_W(WADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W), .N_RD(N_RD), .BYPASS(0))
    u_dut_nb (.clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .bus(bus_nb));

  // Reference state: slice contents, sweep rows still to clear, expected read outputs.
  logic [7:0] m_mem [8][4];
  int         m_left;
  logic [7:0] e_d1 [2];
  logic [7:0] e_d0 [2];
  logic [1:0] e_v;
  logic       e_done;

  typedef struct {
    logic [3:0]  wstrb;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  ren;
    logic [4:0]  a0, a1;
    logic [1:0]  ev;
    logic [7:0]  d0, d1, d0nb;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int r = 0; r < 8; r++) for (int j = 0; j < 4; j++) m_mem[r][j] = 8'h00;
    m_left = 0; e_v = 2'b00; e_done = 1'b0;
    for (int k = 0; k < 2; k++) begin e_d1[k] = 8'h00; e_d0[k] = 8'h00; end
  endtask

  task automatic check_outs();
    chk("busy", {31'd0, bus.busy_o}, {31'd0, m_left != 0});
    chk("wready", {31'd0, bus.wready_o}, {31'd0, m_left == 0});
    chk("done", {31'd0, bus.done_o}, {31'd0, e_done});
    chk("done_nb", {31'd0, bus_nb.done_o}, {31'd0, e_done});
    chk("rvalid", {30'd0, bus.rvalid_o}, {30'd0, e_v});
    chk("rvalid_nb", {30'd0, bus_nb.rvalid_o}, {30'd0, e_v});
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rdata%0d", k), {24'd0, bus.rdata_o[k*8 +: 8]}, {24'd0, e_d1[k]});
      chk($sformatf("rdata%0d_nb", k), {24'd0, bus_nb.rdata_o[k*8 +: 8]}, {24'd0, e_d0[k]});
    end
  endtask

  // Predict the edge from current inputs, take the edge, compare.
  task automatic step();
    int row, sl;
    logic [7:0] old, nw;
    bit busy;
    if (cke_i) begin
      busy = (m_left != 0);
      for (int k = 0; k < 2; k++) begin
        if (bus.ren_i[k] && !busy) begin
          row = int'(bus.raddr_i[k*5+2 +: 3]);
          sl  = int'(bus.raddr_i[k*5 +: 2]);
          old = m_mem[row][sl];
          nw  = (bus.wstrb_i[sl] && int'(bus.waddr_i) == row) ? bus.wdata_i[sl*8 +: 8] : old;
          e_d1[k] = nw; e_d0[k] = old; e_v[k] = 1'b1;
        end else e_v[k] = 1'b0;
      end
      if (!busy)
        for (int j = 0; j < 4; j++) if (bus.wstrb_i[j]) m_mem[bus.waddr_i][j] = bus.wdata_i[j*8 +: 8];
      e_done = 1'b0;
      if (busy) begin
        for (int j = 0; j < 4; j++) m_mem[8 - m_left][j] = 8'h00;
        m_left--;
        e_done = (m_left == 0);
      end else if (bus.clr_i) m_left = 8;
    end else e_done = 1'b0;
    @(posedge clk_i); #1;
    check_outs();
  endtask

  task automatic idle();
    bus.clr_i = 1'b0; bus.wstrb_i = '0; bus.ren_i = '0; cke_i = 1'b1;
  endtask

  task automatic set_wr(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
    bus.waddr_i = a; bus.wstrb_i = s; bus.wdata_i = d;
  endtask

  task automatic set_rd(input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1);
    bus.ren_i = r; bus.raddr_i = {a1, a0};
  endtask

  task automatic rand_act();
    set_wr(3'($urandom), 4'($urandom), $urandom);
    set_rd(2'($urandom), 5'($urandom), 5'($urandom));
  endtask

  task automatic do_reset();
    arst_n_i = 1'b0; #1;
    model_zero();
    check_outs();
    @(posedge clk_i); #1;
    arst_n_i = 1'b1;
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a < 32; a++) begin
      idle(); set_rd(2'b11, 5'(a), 5'(31 - a));
      step();
      chk(nm, {16'd0, bus.rdata_o}, 32'd0);
    end
    idle(); step();
  endtask

  initial begin
    int nbusy, ndone;
    bus.clr_i = 1'b0; bus.wstrb_i = '0; bus.waddr_i = '0; bus.wdata_i = '0;
    bus.ren_i = '0; bus.raddr_i = '0;
    tbl[0] = '{4'b0101, 3'd2, 32'hAABBCCDD, 2'b00, 5'd0,  5'd0,  2'b00, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{4'b0000, 3'd0, 32'h0,       2'b11, 5'd8,  5'd9,  2'b11, 8'hDD, 8'h00, 8'hDD};
    tbl[2] = '{4'b0000, 3'd0, 32'h0,       2'b11, 5'd10, 5'd11, 2'b11, 8'hBB, 8'h00, 8'hBB};
    tbl[3] = '{4'b0000, 3'd0, 32'h0,       2'b01, 5'd11, 5'd0,  2'b01, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{4'b1111, 3'd1, 32'h11223344, 2'b01, 5'd5, 5'd0,  2'b01, 8'h33, 8'h00, 8'h00};
    tbl[5] = '{4'b0000, 3'd0, 32'h0,       2'b11, 5'd5,  5'd4,  2'b11, 8'h33, 8'h44, 8'h33};

    // Reset state, then every address on both ports.
    #2; do_reset();
    check_outs();
    read_all_zero("reset_read");

    // Strobed write, slice reads and same-cycle collision.
    foreach (tbl[i]) begin
      idle();
      set_wr(tbl[i].waddr, tbl[i].wstrb, tbl[i].wdata);
      set_rd(tbl[i].ren, tbl[i].a0, tbl[i].a1);
      step();
      chk($sformatf("tbl%0d_v", i), {30'd0, bus.rvalid_o}, {30'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_d0", i), {24'd0, bus.rdata_o[7:0]}, {24'd0, tbl[i].d0});
      chk($sformatf("tbl%0d_d1", i), {24'd0, bus.rdata_o[15:8]}, {24'd0, tbl[i].d1});
      chk($sformatf("tbl%0d_d0nb", i), {24'd0, bus_nb.rdata_o[7:0]}, {24'd0, tbl[i].d0nb});
    end

    // Fill with 0xFF, sweep with a same-cycle write and a mid-sweep clr.
    for (int r = 0; r < 8; r++) begin idle(); set_wr(3'(r), 4'hF, 32'hFFFFFFFF); step(); end
    idle(); set_wr(3'd3, 4'hF, 32'h12345678); bus.clr_i = 1'b1; step();
    nbusy = int'(bus.busy_o); ndone = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i < 8) rand_act();
      if (i == 3) bus.clr_i = 1'b1;
      step();
      nbusy += int'(bus.busy_o); ndone += int'(bus.done_o);
    end
    chk("sweep_busy_cycles", 32'(nbusy), 32'd8);
    chk("sweep_done_pulses", 32'(ndone), 32'd1);
    read_all_zero("post_sweep_read");

    // Clock enable low: frozen outputs, array and sweep counter.
    idle(); set_wr(3'd6, 4'hF, 32'hCAFEF00D); step();
    idle(); set_rd(2'b11, 5'd24, 5'd27); step();
    for (int i = 0; i < 3; i++) begin
      idle(); cke_i = 1'b0; set_wr(3'd6, 4'hF, 32'h01020304); set_rd(2'b11, 5'd25, 5'd26); bus.clr_i = 1'b1;
      step();
    end
    chk("cke_hold_d0", {24'd0, bus.rdata_o[7:0]}, 32'h0D);
    idle(); set_rd(2'b01, 5'd25, 5'd0); step();
    chk("cke_no_write", {24'd0, bus.rdata_o[7:0]}, 32'hF0);
    idle(); bus.clr_i = 1'b1; step();
    nbusy = int'(bus.busy_o);
    for (int i = 0; i < 12; i++) begin
      idle(); if (i >= 2 && i < 5) cke_i = 1'b0;
      step();
      nbusy += int'(bus.busy_o);
    end
    chk("cke_stall_busy", 32'(nbusy), 32'd11);

    // Reset mid-read and mid-sweep.
    idle(); set_wr(3'd2, 4'hF, 32'h55667788); step();
    idle(); set_rd(2'b11, 5'd8, 5'd11); step();
    #2; do_reset();
    chk("rst_rdata", {16'd0, bus.rdata_o}, 32'd0);
    for (int r = 0; r < 8; r++) begin idle(); set_wr(3'(r), 4'hF, 32'hFFFFFFFF); step(); end
    idle(); bus.clr_i = 1'b1; step();
    for (int i = 0; i < 3; i++) begin idle(); rand_act(); step(); end
    #2; do_reset();
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin idle(); step(); ndone += int'(bus.done_o); end
    chk("rst_no_done", 32'(ndone), 32'd0);
    read_all_zero("post_rst_read");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      idle();
      rand_act();
      if ($urandom_range(0, 3) == 0) bus.wstrb_i = '0;
      if ($urandom_range(0, 3) == 0) bus.raddr_i[4:2] = bus.waddr_i;
      cke_i = ($urandom_range(0, 7) != 0);
      bus.clr_i = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
